wait_timer: RTL and testbench
=============================

// Module: wait_timer
// PURPOSE
//  Parametrised busy-wait timer for the hrm-cpu WAIT instruction path.
//  On start, loads a unit count and holds busy for exactly count*TICK clocks.
//  Then pulses done for one cycle. Adds configurable width, abort, remaining-count
//  visibility and an optional retrigger mode. Sits beside the control FSM, which
//  stalls while busy=1.
// PARAMETERS
//  W     8   width of din/remaining (units); legal 1..32
//  TICK  5   clocks per unit; legal >=1; prescaler width PW = max(1,$clog2(TICK))
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   reset, synchronous, active-high
//  din        in   W   unit count, sampled on the cycle start=1 is accepted
//  start      in   1   request; level-sampled each cycle
//  abort      in   1   cancel a running wait
//  busy       out  1   1 while a wait is counting
//  done       out  1   one-cycle pulse after natural completion
//  remaining  out  W   units still to elapse (0 when not busy)
// BEHAVIOUR
//  - Reset values: state=IDLE, busy=0, done=0, remaining=0, prescaler=0.
//  - rst mid-operation: next cycle is IDLE; no done pulse; all outputs 0.
//  - States: IDLE, RUN, DONE. All outputs are registered (no comb paths in->out).
//  - IDLE:
//    - start=1 & din!=0 & abort=0 -> RUN, remaining<=din, prescaler<=0.
//    - start with din==0 is ignored: stays IDLE, no busy, no done.
//  - RUN (busy=1): prescaler counts 0..TICK-1.
//    - When prescaler==TICK-1: prescaler<=0 and remaining<=remaining-1.
//    - If remaining was 1 on that cycle -> DONE.
//  - Latency: start accepted at edge N -> busy=1 from N+1 through N+din*TICK.
//    - Busy is high for exactly din*TICK cycles.
//    - DONE is the next cycle: busy=0, done=1, remaining=0.
//  - DONE lasts one cycle, then IDLE.
//    - start in DONE is accepted exactly as in IDLE, so back-to-back waits cost
//      one DONE cycle.
//  - abort=1 in RUN -> IDLE next cycle: busy=0, remaining=0, done stays 0.
//  - abort has priority over start in every state; abort in IDLE/DONE has no
//    effect beyond blocking start.
//  - TICK=1: remaining decrements every RUN cycle; prescaler is held at 0.
//  - remaining never wraps: decrement occurs only while remaining>=1.
//  - din max (2^W-1) is legal: busy for (2^W-1)*TICK cycles.
// CONFIGURATION
//  WAIT_TIMER_RETRIGGER_EN defined:
//    - start=1 & din!=0 & abort=0 in RUN reloads remaining<=din, prescaler<=0.
//    - busy stays 1 with no gap; no done for the cancelled wait.
//    - start with din==0 in RUN is ignored.
//  WAIT_TIMER_RETRIGGER_EN undefined:
//    - start in RUN is ignored entirely; the current wait completes unchanged.
// TESTING
//  1 W=8,TICK=5: din=3,start 1 cycle -> busy=1 exactly 15 cycles; done=1 on
//    cycle 16; remaining 3,2,1 then 0.
//  2 din=0,start=1 -> busy and done stay 0 for 20 cycles; remaining=0.
//  3 din=4 running; abort at busy cycle 7 -> busy=0 next cycle, done never
//    pulses, remaining=0.
//  4 TICK=1: din=255 -> busy 255 cycles, done once; start held high
//    -> restarts after the single DONE cycle.
//  5 rst asserted mid-RUN (remaining=2) -> next cycle busy=0, done=0, remaining=0.
//  6 With _EN: din=2 running; start din=5 at busy cycle 8 -> busy continuous,
//    ends 25 cycles after reload, one done. Without _EN: ends at cycle 10,
//    second start ignored.

Source files
------------

// File: rtl/wait_timer_if.sv
// Handshake bundle between the control FSM (master) and wait_timer (slave).
interface wait_timer_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         start;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] remaining;

  modport master (
    output din, start, abort,
    input  busy, done, remaining
  );

  modport slave (
    input  din, start, abort,
    output busy, done, remaining
  );
endinterface

// File: rtl/wait_timer.sv
// Busy-wait timer for the WAIT instruction: busy for din*TICK clocks, then a one-cycle done.
// Optional WAIT_TIMER_RETRIGGER_EN lets a new start reload a wait that is still running.
module wait_timer #(
  parameter int W    = 8,
  parameter int TICK = 5
) (
  input  logic         clk,
  input  logic         rst,
  wait_timer_if.slave  bus
);

  localparam int PW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   remaining_q, remaining_nxt;
  logic [PW-1:0]  presc_q, presc_nxt;
  logic           accept;
  logic           tick_end;

  // Abort always wins, and a zero count is never worth entering RUN for.
  always_comb begin
    accept   = bus.start && !bus.abort && (bus.din != '0);
    tick_end = (presc_q == PRESC_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining_q <= '0;
      presc_q     <= '0;
    end else begin
      state       <= state_nxt;
      remaining_q <= remaining_nxt;
      presc_q     <= presc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining_q;
    presc_nxt     = presc_q;
    case (state)
      IDLE, DONE: begin
        presc_nxt = '0;
        if (accept) begin
          state_nxt     = RUN;
          remaining_nxt = bus.din;
        end else begin
          state_nxt     = IDLE;
          remaining_nxt = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt     = IDLE;
          remaining_nxt = '0;
          presc_nxt     = '0;
        end
`ifdef WAIT_TIMER_RETRIGGER_EN
        else if (accept) begin
          remaining_nxt = bus.din;
          presc_nxt     = '0;
        end
`endif
        else if (tick_end) begin
          presc_nxt = '0;
          if (remaining_q != '0)
            remaining_nxt = remaining_q - W'(1);
          if (remaining_q <= W'(1))
            state_nxt = DONE;
        end else begin
          presc_nxt = presc_q + PW'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        remaining_nxt = '0;
        presc_nxt     = '0;
      end
    endcase
  end

  // Outputs decode only registered state, so there is no input-to-output path.
  always_comb begin
    bus.busy      = (state == RUN);
    bus.done      = (state == DONE);
    bus.remaining = remaining_q;
  end

endmodule

// File: tb/tb_wait_timer.sv
// Self-checking bench for wait_timer: table-driven vectors on a TICK=5 instance,
// hand sequences for reset mid-run and a TICK=1 instance running a full 255-unit wait.
module tb_wait_timer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wait_timer_if #(.W(8)) bus5 ();
  wait_timer_if #(.W(8)) bus1 ();

  wait_timer #(.W(8), .TICK(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  wait_timer #(.W(8), .TICK(1)) dut_t1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    string      name;
    logic       start;
    logic       abort;
    logic [7:0] din;
    logic       exp_busy;
    logic       exp_done;
    logic [7:0] exp_rem;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add_vec(input string n, input logic s, input logic a,
                                  input logic [7:0] d, input logic b,
                                  input logic dn, input logic [7:0] r);
    vec_t v;
    v.name = n; v.start = s; v.abort = a; v.din = d;
    v.exp_busy = b; v.exp_done = dn; v.exp_rem = r;
    vecs.push_back(v);
  endfunction

  // Inputs change on the falling edge; outputs are looked at 1 time unit after the rising edge.
  task automatic applyStimulus(input bit on_t1, input logic s, input logic a,
                               input logic [7:0] d);
    @(negedge clk);
    if (on_t1) begin
      bus1.start = s; bus1.abort = a; bus1.din = d;
    end else begin
      bus5.start = s; bus5.abort = a; bus5.din = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, rem_errs, stray;

    bus5.start = 1'b0; bus5.abort = 1'b0; bus5.din = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.din = '0;
    rst = 1'b1;

    // ---------------- vector table ----------------
    // Each entry: inputs seen at the next rising edge, outputs expected after it.
    add_vec("t1_start", 1, 0, 8'd3, 1, 0, 8'd3);
    for (int k = 2; k <= 15; k++)
      add_vec("t1_run", 0, 0, 8'd0, 1, 0, (k <= 5) ? 8'd3 : (k <= 10) ? 8'd2 : 8'd1);
    add_vec("t1_done", 0, 0, 8'd0, 0, 1, 8'd0);
    add_vec("t1_idle", 0, 0, 8'd0, 0, 0, 8'd0);

    for (int k = 0; k < 20; k++)
      add_vec("t2_din0", 1, 0, 8'd0, 0, 0, 8'd0);
    add_vec("abort_blocks_idle", 1, 1, 8'd7, 0, 0, 8'd0);

    add_vec("t3_start", 1, 0, 8'd4, 1, 0, 8'd4);
    for (int k = 2; k <= 7; k++)
      add_vec("t3_run", 0, 0, 8'd0, 1, 0, (k <= 5) ? 8'd4 : 8'd3);
    add_vec("t3_abort", 0, 1, 8'd0, 0, 0, 8'd0);
    for (int k = 0; k < 6; k++)
      add_vec("t3_no_done", 0, 0, 8'd0, 0, 0, 8'd0);

    add_vec("done_a_start", 1, 0, 8'd1, 1, 0, 8'd1);
    for (int k = 2; k <= 5; k++)
      add_vec("done_a_run", 0, 0, 8'd0, 1, 0, 8'd1);
    add_vec("done_a_done", 0, 0, 8'd0, 0, 1, 8'd0);
    add_vec("abort_blocks_done", 1, 1, 8'd9, 0, 0, 8'd0);

    add_vec("done_b_start", 1, 0, 8'd1, 1, 0, 8'd1);
    for (int k = 2; k <= 5; k++)
      add_vec("done_b_run", 0, 0, 8'd0, 1, 0, 8'd1);
    add_vec("done_b_done", 0, 0, 8'd0, 0, 1, 8'd0);
    add_vec("b2b_start", 1, 0, 8'd2, 1, 0, 8'd2);
    for (int k = 2; k <= 10; k++)
      add_vec("b2b_run", 0, 0, 8'd0, 1, 0, (k <= 5) ? 8'd2 : 8'd1);
    add_vec("b2b_done", 0, 0, 8'd0, 0, 1, 8'd0);
    add_vec("b2b_idle", 0, 0, 8'd0, 0, 0, 8'd0);

    add_vec("t6_start", 1, 0, 8'd2, 1, 0, 8'd2);
    for (int k = 2; k <= 8; k++)
      add_vec("t6_run", 0, 0, 8'd0, 1, 0, (k <= 5) ? 8'd2 : 8'd1);
`ifdef WAIT_TIMER_RETRIGGER_EN
    add_vec("t6_reload", 1, 0, 8'd5, 1, 0, 8'd5);
    for (int r = 2; r <= 25; r++)
      add_vec("t6_rerun", 0, 0, 8'd0, 1, 0, 8'(5 - (r - 1) / 5));
    add_vec("t6_done", 0, 0, 8'd0, 0, 1, 8'd0);
`else
    add_vec("t6_ignored", 1, 0, 8'd5, 1, 0, 8'd1);
    add_vec("t6_run10", 0, 0, 8'd0, 1, 0, 8'd1);
    add_vec("t6_done", 0, 0, 8'd0, 0, 1, 8'd0);
`endif
    add_vec("t6_idle", 0, 0, 8'd0, 0, 0, 8'd0);

    // ---------------- reset state ----------------
    applyStimulus(0, 0, 0, 8'd0);
    applyStimulus(0, 0, 0, 8'd0);
    checkOutput("rst_busy", 32'(bus5.busy), 32'd0);
    checkOutput("rst_done", 32'(bus5.done), 32'd0);
    checkOutput("rst_rem", 32'(bus5.remaining), 32'd0);
    checkOutput("rst_t1_busy", 32'(bus1.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table run ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].start, vecs[i].abort, vecs[i].din);
      checkOutput($sformatf("%s[%0d].busy", vecs[i].name, i), 32'(bus5.busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("%s[%0d].done", vecs[i].name, i), 32'(bus5.done), 32'(vecs[i].exp_done));
      checkOutput($sformatf("%s[%0d].rem", vecs[i].name, i), 32'(bus5.remaining), 32'(vecs[i].exp_rem));
    end

    // ---------------- reset mid-run ----------------
    applyStimulus(0, 1, 0, 8'd3);
    for (int k = 2; k <= 6; k++)
      applyStimulus(0, 0, 0, 8'd0);
    checkOutput("t5_pre_rem", 32'(bus5.remaining), 32'd2);
    checkOutput("t5_pre_busy", 32'(bus5.busy), 32'd1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 8'd0);
    checkOutput("t5_busy", 32'(bus5.busy), 32'd0);
    checkOutput("t5_done", 32'(bus5.done), 32'd0);
    checkOutput("t5_rem", 32'(bus5.remaining), 32'd0);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(0, 0, 0, 8'd0);
      if (bus5.busy || bus5.done || bus5.remaining != 8'd0) stray++;
    end
    checkOutput("t5_quiet_after", 32'(stray), 32'd0);

    // ---------------- TICK=1, full-scale count, start held ----------------
    applyStimulus(1, 1, 0, 8'd255);
    checkOutput("t4_first_busy", 32'(bus1.busy), 32'd1);
    checkOutput("t4_first_rem", 32'(bus1.remaining), 32'd255);
    busy_cnt = bus1.busy ? 1 : 0;
    done_cnt = 0;
    rem_errs = 0;
    for (int i = 0; i < 600 && bus1.busy; i++) begin
      applyStimulus(1, 1, 0, 8'd255);
      if (bus1.busy) begin
        busy_cnt++;
        if (bus1.remaining != 8'(256 - busy_cnt)) rem_errs++;
      end
      if (bus1.done) done_cnt++;
    end
    checkOutput("t4_busy_cycles", 32'(busy_cnt), 32'd255);
    checkOutput("t4_rem_track", 32'(rem_errs), 32'd0);
    checkOutput("t4_done_once", 32'(done_cnt), 32'd1);
    checkOutput("t4_done_rem", 32'(bus1.remaining), 32'd0);
    applyStimulus(1, 1, 0, 8'd255);
    checkOutput("t4_restart_busy", 32'(bus1.busy), 32'd1);
    checkOutput("t4_restart_done", 32'(bus1.done), 32'd0);
    checkOutput("t4_restart_rem", 32'(bus1.remaining), 32'd255);
    applyStimulus(1, 0, 0, 8'd0);
    checkOutput("t4_tick_rem", 32'(bus1.remaining), 32'd254);
    applyStimulus(1, 1, 1, 8'd255);
    checkOutput("t4_abort_busy", 32'(bus1.busy), 32'd0);
    checkOutput("t4_abort_done", 32'(bus1.done), 32'd0);
    checkOutput("t4_abort_rem", 32'(bus1.remaining), 32'd0);
    applyStimulus(1, 0, 0, 8'd0);
    checkOutput("t4_stay_idle", 32'(bus1.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
